// File: rtl/spmp_csr_regfile_pkg.sv
// Shared SPMP definitions: CSR addresses, spmpcfg byte layout, clear FSM states.
// SPMP_NA4_EN makes A=NA4 a legal, storable mode; otherwise it is written as OFF.
package spmp_csr_regfile_pkg;

    localparam logic [11:0] CSR_SPMPCFG0   = 12'h1A0;
    localparam logic [11:0] CSR_SPMPADDR0  = 12'h1B0;
    localparam logic [11:0] CSR_SPMPSWITCH = 12'h170;

    localparam int unsigned SPMPCFG_R_BIT    = 0;
    localparam int unsigned SPMPCFG_W_BIT    = 1;
    localparam int unsigned SPMPCFG_X_BIT    = 2;
    localparam int unsigned SPMPCFG_A_LSB    = 3;
    localparam int unsigned SPMPCFG_A_MSB    = 4;
    localparam int unsigned SPMPCFG_RSVD_BIT = 5;
    localparam int unsigned SPMPCFG_S_BIT    = 6;
    localparam int unsigned SPMPCFG_L_BIT    = 7;

    localparam logic [1:0] A_OFF   = 2'b00;
    localparam logic [1:0] A_TOR   = 2'b01;
    localparam logic [1:0] A_NA4   = 2'b10;
    localparam logic [1:0] A_NAPOT = 2'b11;

`ifdef SPMP_NA4_EN
    localparam bit NA4_EN = 1'b1;
`else
    localparam bit NA4_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} spmp_clr_state_e;

    typedef struct packed {
        logic       l;
        logic       s;
        logic       rsvd;
        logic [1:0] a;
        logic       x;
        logic       w;
        logic       r;
    } spmpcfg_t;

endpackage

// File: rtl/spmp_cfg_legalizer.sv
// WARL legalisation of one spmpcfg byte lane; also reports whether the matching
// spmpaddr is write-protected. NA4 handling follows SPMP_NA4_EN (see package).
module spmp_cfg_legalizer
    import spmp_csr_regfile_pkg::*;
(
    input  logic [7:0] old_cfg,
    input  logic [7:0] new_cfg,
    input  logic       next_lock_tor,
    output logic [7:0] legal_cfg,
    output logic       changed,
    output logic       addr_lock
);

    logic [7:0] n;
    logic       rwx_none;

    always_comb begin
        n = new_cfg;
        n[SPMPCFG_RSVD_BIT] = 1'b0;
        if (!NA4_EN && n[SPMPCFG_A_MSB:SPMPCFG_A_LSB] == A_NA4)
            n[SPMPCFG_A_MSB:SPMPCFG_A_LSB] = A_OFF;
        rwx_none = !(n[SPMPCFG_R_BIT] | n[SPMPCFG_W_BIT] | n[SPMPCFG_X_BIT]);
        // S with no permissions is reserved; R=0,W=1 without S is a legal shared encoding
        if (old_cfg[SPMPCFG_L_BIT] || (n[SPMPCFG_S_BIT] && rwx_none))
            legal_cfg = old_cfg;
        else
            legal_cfg = n;
    end

    assign changed   = (legal_cfg != old_cfg);
    assign addr_lock = old_cfg[SPMPCFG_L_BIT] | next_lock_tor;

endmodule

// File: rtl/spmp_csr_regfile.sv
// SPMP configuration register file: CSR access with WARL/lock rules, flush on
// effective change and a bulk-clear FSM. NA4 legality is set by SPMP_NA4_EN.
module spmp_csr_regfile
    import spmp_csr_regfile_pkg::*;
#(
    parameter int unsigned NrSPMPEntries = 8,
    parameter int unsigned PLEN          = 56,
    parameter int unsigned Grain         = 0,
    localparam int unsigned NE = (NrSPMPEntries > 0) ? NrSPMPEntries : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         csr_valid_i,
    output logic                         csr_ready_o,
    input  logic                         csr_we_i,
    input  logic [11:0]                  csr_addr_i,
    input  logic [63:0]                  csr_wdata_i,
    output logic                         csr_rvalid_o,
    output logic [63:0]                  csr_rdata_o,
    output logic                         csr_err_o,
    input  logic                         clear_req_i,
    output logic                         clear_done_o,
    output spmpcfg_t [NE-1:0]            spmpcfg_o,
    output logic [NE-1:0][PLEN-3:0]      spmpaddr_o,
    output logic [63:0]                  spmpswitch_o,
    output logic                         flush_o
);

    spmp_clr_state_e          state_q, state_d;
    logic [5:0]               idx_q;
    spmpcfg_t [NE-1:0]        cfg_q, cfg_d;
    logic [NE-1:0][PLEN-3:0]  addr_q, addr_d;
    logic [63:0]              sw_q, sw_d, sw_mask;

    logic        acc, wr_acc, rd_acc;
    logic        cfg_hit, addr_hit, sw_hit, bad;
    logic [5:0]  aj;
    logic [2:0]  grp;
    logic [7:0][7:0] lane_old, lane_new, lane_legal;
    logic [7:0]  lane_en, lane_nlt, lane_chg, lane_alock;
    logic        upd_chg;
    logic [63:0] rd;
    logic        rvalid_q, err_q, flush_q;
    logic [63:0] rdata_q;

    function automatic logic [PLEN-3:0] addr_view(input logic [PLEN-3:0] a, input logic [1:0] mode);
        logic [PLEN-3:0] v;
        v = a;
        for (int i = 0; i < int'(PLEN) - 2; i++) begin
            if (mode == A_NAPOT && i < int'(Grain) - 1) v[i] = 1'b1;
            else if (mode != A_NAPOT && i < int'(Grain)) v[i] = 1'b0;
        end
        return v;
    endfunction

    // ---------------- decode ----------------
    assign acc    = csr_valid_i & csr_ready_o;
    assign wr_acc = acc & csr_we_i;
    assign rd_acc = acc & ~csr_we_i;
    assign aj     = csr_addr_i[5:0] - CSR_SPMPADDR0[5:0];

    assign cfg_hit  = (csr_addr_i[11:4] == CSR_SPMPCFG0[11:4]) && !csr_addr_i[0]
                      && ((32'(csr_addr_i[3:1]) * 32'd8) < NrSPMPEntries);
    assign addr_hit = (csr_addr_i >= CSR_SPMPADDR0) && (csr_addr_i < CSR_SPMPADDR0 + 12'd64)
                      && (32'(aj) < NrSPMPEntries);
    assign sw_hit   = (csr_addr_i == CSR_SPMPSWITCH) && (NrSPMPEntries != 0);
    assign bad      = ~(cfg_hit | addr_hit | sw_hit);
    // cfg writes pick their group from the address; addr writes need the group holding cfg j and j+1
    assign grp      = cfg_hit ? csr_addr_i[3:1] : aj[5:3];

    always_comb begin
        lane_old = '0;
        lane_nlt = '0;
        lane_en  = '0;
        for (int b = 0; b < 8; b++) begin
            for (int e = 0; e < int'(NrSPMPEntries); e++) begin
                if (e == int'(grp) * 8 + b) begin
                    lane_old[b] = cfg_q[e];
                    lane_en[b]  = 1'b1;
                end
                if (e == int'(grp) * 8 + b + 1)
                    lane_nlt[b] = cfg_q[e].l && (cfg_q[e].a == A_TOR);
            end
        end
    end

    assign lane_new = csr_wdata_i;

    for (genvar b = 0; b < 8; b++) begin : g_lane
        spmp_cfg_legalizer u_legalizer (
            .old_cfg       (lane_old[b]),
            .new_cfg       (lane_new[b]),
            .next_lock_tor (lane_nlt[b]),
            .legal_cfg     (lane_legal[b]),
            .changed       (lane_chg[b]),
            .addr_lock     (lane_alock[b])
        );
    end

    always_comb begin
        sw_mask = '0;
        for (int i = 0; i < int'(NrSPMPEntries) && i < 64; i++) sw_mask[i] = 1'b1;
    end

    // ---------------- register next-state ----------------
    always_comb begin
        cfg_d  = cfg_q;
        addr_d = addr_q;
        sw_d   = sw_q;
        if (state_q == CLEAR) begin
            for (int e = 0; e < int'(NE); e++) begin
                if (e == int'(idx_q)) begin
                    cfg_d[e]  = '0;
                    addr_d[e] = '0;
                end
            end
            sw_d[idx_q] = 1'b0;
        end else if (wr_acc) begin
            for (int e = 0; e < int'(NrSPMPEntries); e++) begin
                if (cfg_hit && (e / 8) == int'(grp))
                    cfg_d[e] = spmpcfg_t'(lane_legal[e % 8]);
                if (addr_hit && e == int'(aj) && !lane_alock[e % 8])
                    addr_d[e] = csr_wdata_i[PLEN-3:0];
            end
            if (sw_hit) sw_d = csr_wdata_i & sw_mask;
        end
    end

    assign upd_chg = (cfg_hit && |(lane_chg & lane_en)) || (addr_d != addr_q) || (sw_d != sw_q);

    always_comb begin
        rd = '0;
        if (cfg_hit) begin
            for (int b = 0; b < 8; b++)
                if (lane_en[b]) rd[8*b +: 8] = lane_old[b];
        end else if (addr_hit) begin
            for (int e = 0; e < int'(NrSPMPEntries); e++)
                if (e == int'(aj)) rd[PLEN-3:0] = addr_view(addr_q[e], cfg_q[e].a);
        end else if (sw_hit) begin
            rd = sw_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q    <= '0;
            addr_q   <= '0;
            sw_q     <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            flush_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            cfg_q    <= cfg_d;
            addr_q   <= addr_d;
            sw_q     <= sw_d;
            rvalid_q <= rd_acc;
            err_q    <= acc & bad;
            flush_q  <= wr_acc & upd_chg;
            rdata_q  <= rd_acc ? rd : '0;
        end
    end

    // ---------------- bulk-clear FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= (state_q == CLEAR) ? idx_q + 6'd1 : 6'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear_req_i) state_d = (NrSPMPEntries == 0) ? DONE : CLEAR;
            CLEAR:   if (32'(idx_q) == NrSPMPEntries - 1) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        csr_ready_o  = (state_q == IDLE);
        clear_done_o = (state_q == DONE);
    end

    assign csr_rvalid_o = rvalid_q;
    assign csr_rdata_o  = rdata_q;
    assign csr_err_o    = err_q;
    assign flush_o      = flush_q | clear_done_o;
    assign spmpcfg_o    = cfg_q;
    assign spmpaddr_o   = addr_q;
    assign spmpswitch_o = sw_q;

endmodule

// File: tb/tb_spmp_csr_regfile.sv
// Directed bench for spmp_csr_regfile (8 entries, PLEN 56, Grain 0).
module tb_spmp_csr_regfile;
    import spmp_csr_regfile_pkg::*;

    localparam int N  = 8;
    localparam int PL = 56;

    logic        clk, rst_n;
    logic        csr_valid, csr_ready, csr_we, csr_rvalid, csr_err;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata, csr_rdata, sw_o;
    logic        clear_req, clear_done, flush;
    spmpcfg_t [N-1:0]         cfg_o;
    logic [N-1:0][PL-3:0]     addr_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic        rv, er, fl;
    logic [63:0] rd;

    spmp_csr_regfile #(.NrSPMPEntries(N), .PLEN(PL), .Grain(0)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .csr_valid_i  (csr_valid),
        .csr_ready_o  (csr_ready),
        .csr_we_i     (csr_we),
        .csr_addr_i   (csr_addr),
        .csr_wdata_i  (csr_wdata),
        .csr_rvalid_o (csr_rvalid),
        .csr_rdata_o  (csr_rdata),
        .csr_err_o    (csr_err),
        .clear_req_i  (clear_req),
        .clear_done_o (clear_done),
        .spmpcfg_o    (cfg_o),
        .spmpaddr_o   (addr_o),
        .spmpswitch_o (sw_o),
        .flush_o      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One accepted request; captures the registered response of the following cycle.
    task automatic csr_req(input logic we, input logic [11:0] a, input logic [63:0] d);
        @(negedge clk);
        csr_valid = 1'b1; csr_we = we; csr_addr = a; csr_wdata = d;
        @(posedge clk); #1;
        csr_valid = 1'b0; csr_we = 1'b0;
        rv = csr_rvalid; rd = csr_rdata; er = csr_err; fl = flush;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_checks++; if (csr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", csr_ready); end
        n_checks++; if (cfg_o !== '0) begin n_fail++; $display("FAIL reset_cfg: got %h want 0", cfg_o); end
        n_checks++; if (addr_o !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr_o); end
        n_checks++; if (sw_o !== 64'h0) begin n_fail++; $display("FAIL reset_switch: got %h want 0", sw_o); end
        n_checks++; if ({flush, clear_done, csr_rvalid, csr_err} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 0000", {flush, clear_done, csr_rvalid, csr_err}); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_cfg_write();
        csr_req(1'b1, 12'h1A0, 64'h1B);
        n_checks++; if (fl !== 1'b1) begin n_fail++; $display("FAIL cfg_wr_flush: got %b want 1", fl); end
        n_checks++; if (cfg_o[0] !== 8'h1B) begin n_fail++; $display("FAIL cfg_out0: got %h want 1b", cfg_o[0]); end
        csr_req(1'b0, 12'h1A0, 64'h0);
        n_checks++; if (rv !== 1'b1 || rd !== 64'h1B) begin n_fail++; $display("FAIL cfg_read: got rv=%b %h want rv=1 1b", rv, rd); end
        @(posedge clk); #1;
        n_checks++; if (csr_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_single: got %b want 0", csr_rvalid); end
        csr_req(1'b1, 12'h1A0, 64'h1B);
        n_checks++; if (fl !== 1'b0) begin n_fail++; $display("FAIL cfg_same_noflush: got %b want 0", fl); end
    endtask

    task automatic test_lock();
        do_reset();
        csr_req(1'b1, 12'h1A0, 64'h9B);
        n_checks++; if (fl !== 1'b1) begin n_fail++; $display("FAIL lock_set_flush: got %b want 1", fl); end
        csr_req(1'b1, 12'h1A0, 64'h00);
        n_checks++; if (fl !== 1'b0) begin n_fail++; $display("FAIL lock_wr_flush: got %b want 0", fl); end
        csr_req(1'b0, 12'h1A0, 64'h0);
        n_checks++; if (rd !== 64'h9B) begin n_fail++; $display("FAIL lock_cfg_kept: got %h want 9b", rd); end
        csr_req(1'b1, 12'h1B0, 64'h55);
        n_checks++; if (fl !== 1'b0) begin n_fail++; $display("FAIL lock_addr_flush: got %b want 0", fl); end
        csr_req(1'b0, 12'h1B0, 64'h0);
        n_checks++; if (rd !== 64'h0) begin n_fail++; $display("FAIL lock_addr_kept: got %h want 0", rd); end
    endtask

    task automatic test_tor_lock();
        do_reset();
        csr_req(1'b1, 12'h1B0, 64'h1111);
        n_checks++; if (fl !== 1'b1) begin n_fail++; $display("FAIL tor_addr0_init: got %b want 1", fl); end
        csr_req(1'b1, 12'h1A0, 64'h8800);
        csr_req(1'b0, 12'h1A0, 64'h0);
        n_checks++; if (rd !== 64'h8800) begin n_fail++; $display("FAIL tor_cfg: got %h want 8800", rd); end
        csr_req(1'b1, 12'h1B0, 64'h1234);
        n_checks++; if (fl !== 1'b0) begin n_fail++; $display("FAIL tor_addr0_flush: got %b want 0", fl); end
        csr_req(1'b0, 12'h1B0, 64'h0);
        n_checks++; if (rd !== 64'h1111) begin n_fail++; $display("FAIL tor_addr0_kept: got %h want 1111", rd); end
        csr_req(1'b1, 12'h1B1, 64'h77);
        csr_req(1'b0, 12'h1B1, 64'h0);
        n_checks++; if (rd !== 64'h0) begin n_fail++; $display("FAIL tor_addr1_own_lock: got %h want 0", rd); end
        csr_req(1'b1, 12'h1B2, 64'h1234);
        n_checks++; if (fl !== 1'b1) begin n_fail++; $display("FAIL tor_addr2_flush: got %b want 1", fl); end
        csr_req(1'b0, 12'h1B2, 64'h0);
        n_checks++; if (rd !== 64'h1234) begin n_fail++; $display("FAIL tor_addr2: got %h want 1234", rd); end
    endtask

    task automatic test_reserved();
        do_reset();
        csr_req(1'b1, 12'h1A0, 64'h03);
        csr_req(1'b1, 12'h1A0, 64'h40);
        n_checks++; if (fl !== 1'b0) begin n_fail++; $display("FAIL srwx0_flush: got %b want 0", fl); end
        csr_req(1'b0, 12'h1A0, 64'h0);
        n_checks++; if (rd !== 64'h03) begin n_fail++; $display("FAIL srwx0_kept: got %h want 03", rd); end
        csr_req(1'b1, 12'h1A0, 64'h02);
        csr_req(1'b0, 12'h1A0, 64'h0);
        n_checks++; if (rd !== 64'h02) begin n_fail++; $display("FAIL w_only: got %h want 02", rd); end
        csr_req(1'b1, 12'h1A0, 64'h23);
        csr_req(1'b0, 12'h1A0, 64'h0);
        n_checks++; if (rd !== 64'h03) begin n_fail++; $display("FAIL rsvd_bit: got %h want 03", rd); end
    endtask

    task automatic test_na4_lanes();
        logic [63:0] exp_na4;
`ifdef SPMP_NA4_EN
        exp_na4 = 64'h13;
`else
        exp_na4 = 64'h03;
`endif
        do_reset();
        csr_req(1'b1, 12'h1A0, 64'h13);
        csr_req(1'b0, 12'h1A0, 64'h0);
        n_checks++; if (rd !== exp_na4) begin n_fail++; $display("FAIL na4: got %h want %h", rd, exp_na4); end
        csr_req(1'b1, 12'h1A0, 64'h8F58_1F0F_2B0A_0903);
        csr_req(1'b0, 12'h1A0, 64'h0);
        n_checks++; if (rd !== 64'h8F00_1F0F_0B0A_0903) begin n_fail++; $display("FAIL lanes: got %h want 8f001f0f0b0a0903", rd); end
        n_checks++; if (cfg_o[7] !== 8'h8F) begin n_fail++; $display("FAIL lane7_out: got %h want 8f", cfg_o[7]); end
        csr_req(1'b1, 12'h1B6, 64'hABC);
        n_checks++; if (fl !== 1'b0) begin n_fail++; $display("FAIL addr6_tor_flush: got %b want 0", fl); end
        csr_req(1'b1, 12'h1B5, 64'h5A5);
        n_checks++; if (fl !== 1'b1 || addr_o[5] !== 54'h5A5) begin n_fail++; $display("FAIL addr5: got fl=%b %h want fl=1 5a5", fl, addr_o[5]); end
    endtask

    task automatic test_switch();
        csr_req(1'b1, 12'h170, 64'hFFFF_FFFF_FFFF_FFFF);
        n_checks++; if (fl !== 1'b1 || sw_o !== 64'hFF) begin n_fail++; $display("FAIL switch_wr: got fl=%b %h want fl=1 ff", fl, sw_o); end
        csr_req(1'b1, 12'h170, 64'h0000_0000_0000_00FF);
        n_checks++; if (fl !== 1'b0) begin n_fail++; $display("FAIL switch_same: got %b want 0", fl); end
        csr_req(1'b0, 12'h170, 64'h0);
        n_checks++; if (rd !== 64'hFF) begin n_fail++; $display("FAIL switch_read: got %h want ff", rd); end
    endtask

    task automatic test_err();
        csr_req(1'b0, 12'h1A1, 64'h0);
        n_checks++; if ({rv, er} !== 2'b11 || rd !== 64'h0) begin n_fail++; $display("FAIL err_odd: got rv=%b er=%b %h want 1 1 0", rv, er, rd); end
        csr_req(1'b1, 12'h1A2, 64'hFF);
        n_checks++; if (er !== 1'b1 || fl !== 1'b0) begin n_fail++; $display("FAIL err_cfg_range: got er=%b fl=%b want 1 0", er, fl); end
        csr_req(1'b0, 12'h1B8, 64'h0);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_addr_range: got %b want 1", er); end
        csr_req(1'b0, 12'h1B7, 64'h0);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL err_addr_last: got %b want 0", er); end
        csr_req(1'b1, 12'h300, 64'h1);
        n_checks++; if (er !== 1'b1 || fl !== 1'b0) begin n_fail++; $display("FAIL err_unmapped: got er=%b fl=%b want 1 0", er, fl); end
    endtask

    task automatic test_clear();
        int low, done_cnt, done_at;
        logic fl_done;
        low = 0; done_cnt = 0; done_at = -1; fl_done = 1'b0;
        @(negedge clk); clear_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1; clear_req = 1'b0;
            if (csr_ready) break;
            low++;
            if (clear_done) begin done_cnt++; done_at = low; fl_done = flush; end
        end
        n_checks++; if (low !== 9) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d want 9", low); end
        n_checks++; if (done_cnt !== 1 || done_at !== 9) begin n_fail++; $display("FAIL clear_done_pulse: got cnt=%0d at=%0d want 1 at 9", done_cnt, done_at); end
        n_checks++; if (fl_done !== 1'b1) begin n_fail++; $display("FAIL clear_flush: got %b want 1", fl_done); end
        n_checks++; if (cfg_o !== '0 || addr_o !== '0 || sw_o !== 64'h0) begin n_fail++; $display("FAIL clear_state: got cfg=%h sw=%h want 0", cfg_o, sw_o); end
        csr_req(1'b1, 12'h1A0, 64'h03);
        n_checks++; if (fl !== 1'b1 || cfg_o[0] !== 8'h03) begin n_fail++; $display("FAIL clear_unlocked: got fl=%b %h want 1 03", fl, cfg_o[0]); end
    endtask

    task automatic test_back_to_back();
        int waited;
        @(negedge clk);
        csr_valid = 1'b1; csr_we = 1'b1; csr_addr = 12'h170; csr_wdata = 64'h0F; clear_req = 1'b1;
        @(posedge clk); #1;
        csr_valid = 1'b0; csr_we = 1'b0; clear_req = 1'b0;
        n_checks++; if (flush !== 1'b1 || csr_ready !== 1'b0 || sw_o !== 64'h0F) begin n_fail++; $display("FAIL b2b_accept: got fl=%b rdy=%b sw=%h want 1 0 0f", flush, csr_ready, sw_o); end
        waited = 0;
        while (!csr_ready && waited < 30) begin @(posedge clk); #1; waited++; end
        n_checks++; if (csr_ready !== 1'b1 || sw_o !== 64'h0) begin n_fail++; $display("FAIL b2b_cleared: got rdy=%b sw=%h want 1 0", csr_ready, sw_o); end
    endtask

    task automatic test_reset_mid_clear();
        int dn;
        csr_req(1'b1, 12'h170, 64'hFF);
        csr_req(1'b1, 12'h1A0, 64'h1B);
        @(negedge clk); clear_req = 1'b1;
        @(posedge clk); #1; clear_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (sw_o !== 64'hFC) begin n_fail++; $display("FAIL clear_progress: got %h want fc", sw_o); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (csr_ready !== 1'b1 || cfg_o !== '0 || sw_o !== 64'h0 || clear_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got rdy=%b sw=%h done=%b want 1 0 0", csr_ready, sw_o, clear_done); end
        @(negedge clk); rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (clear_done) dn++; end
        n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d want 0", dn); end
    endtask

    initial begin
        rst_n = 1'b0; csr_valid = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0; clear_req = 1'b0;
        test_reset();
        test_cfg_write();
        test_lock();
        test_tor_lock();
        test_reserved();
        test_na4_lanes();
        test_switch();
        test_err();
        test_clear();
        test_back_to_back();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
